instr_cache: RTL and testbench
==============================

INSTR_CACHE -- requirements
Module: instr_cache

Interface
REQ-001 SHALL have parameter LINES, default 16, number of direct-mapped lines; power of two, at least 2.
REQ-002 SHALL have parameter WORDS, default 4, 32-bit words per line; fixed at 4.
REQ-003 SHALL have port i_clock, input, 1: sole clock; all state changes on the rising edge.
REQ-004 SHALL have port i_reset, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports i_cache_address[2], input, 32 each: fetch addresses from the loader.
REQ-006 SHALL have ports i_cache_read[2], input, 1 each: lookup request per port.
REQ-007 SHALL have ports o_cache_instr[2], output, 32 each: instruction word per port.
REQ-008 SHALL have ports o_cache_hit[2], output, 1 each: o_cache_instr valid this cycle.
REQ-009 SHALL have port o_mem_address, output, 32: word address to backing memory.
REQ-010 SHALL have port o_mem_read, output, 1: memory read request.
REQ-011 SHALL have port i_mem_data, input, 32: memory read data.
REQ-012 SHALL have port i_mem_ready, input, 1: i_mem_data valid; consumes the current request.
REQ-013 SHALL have port i_invalidate, input, 1: flush all lines.
REQ-014 SHALL have ports o_hit_count and o_miss_count, output, 32 each: statistics counters (see Configuration).

Function
REQ-015 Address split SHALL be: bits[1:0] ignored; offset bits[3:2]; index bits[3+log2(LINES):4]; tag is all remaining upper bits.
REQ-016 Lookup SHALL be combinational: o_cache_hit[p] = i_cache_read[p] & valid[index] & (tag match), in the same cycle as the request.
REQ-017 o_cache_instr[p] SHALL be the addressed word when o_cache_hit[p]=1, else NOP_INSTR.
REQ-018 The refill FSM SHALL have states IDLE, REFILL and DONE.
REQ-019 In IDLE, a port with i_cache_read=1 and no hit SHALL start a refill of its line; port 0 has priority over port 1.
REQ-020 On REFILL entry, valid[index] SHALL clear, and the line base (offset 0) and tag SHALL be latched.
REQ-021 In REFILL, o_mem_read=1 and o_mem_address=base+4*k SHALL be held stable until i_mem_ready=1.
REQ-022 On each i_mem_ready=1, i_mem_data SHALL be written to word k and k SHALL increment; after word 3 the FSM SHALL go to DONE.
REQ-023 DONE SHALL set the tag and valid[index]=1, then return to IDLE; hits on the refilled line start the cycle after DONE.
REQ-024 Best-case miss-to-hit latency SHALL be 6 cycles: 1 detect + 4 words + DONE.
REQ-025 When both ports miss on the same line, one refill SHALL serve both.
REQ-026 When both ports miss on different lines, refills SHALL run sequentially: port 0 first, then port 1 as it is still missing in IDLE.
REQ-027 Hits to other valid lines SHALL continue to be served during REFILL.
REQ-028 Outside REFILL, o_mem_read SHALL be 0 and o_mem_address SHALL be 0.
REQ-029 i_invalidate=1 SHALL clear all valid bits on the next edge; in REFILL or DONE it also aborts to IDLE without setting valid.
REQ-030 i_invalidate SHALL have priority over a simultaneous miss start and over DONE.
REQ-031 A lookup in the same cycle as i_invalidate SHALL use the old valid bits.

Reset
REQ-032 When i_reset=0, outputs SHALL clear immediately: state=IDLE, all valid=0, k=0, o_mem_read=0, o_mem_address=0, counters=0.
REQ-033 When i_reset=0, o_cache_hit SHALL be 0 and o_cache_instr SHALL be NOP_INSTR.
REQ-034 Reset mid-refill SHALL abandon the refill; a late i_mem_ready after reset SHALL be ignored.
REQ-035 Data array contents need no reset.

Configuration
REQ-036 Macro INSTR_CACHE_STATS_EN defined: o_hit_count SHALL add the number of asserted o_cache_hit bits (0/1/2) per cycle.
REQ-037 Macro INSTR_CACHE_STATS_EN defined: o_miss_count SHALL add 1 per refill started; both counters wrap modulo 2^32.
REQ-038 Macro INSTR_CACHE_STATS_EN undefined: o_hit_count and o_miss_count SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-039 Cold read: both ports read 0x100 and 0x104; memory returns 0xA0..0xA3 with ready every cycle -> o_mem_address 0x100, 0x104, 0x108, 0x10C; both hits with 0xA0 and 0xA1 on cycle 6.
REQ-040 Conflict: after 0x100 is cached, port 0 reads 0x100 and port 1 reads 0x200 with LINES=16 -> port 0 hits; port 1 refill evicts the line; a re-read of 0x100 then misses.
REQ-041 Stall: i_mem_ready low 3 cycles on word 2 -> o_mem_address holds 0x108 with o_mem_read=1; line valid only after DONE.
REQ-042 Flush: i_invalidate during word 1 of a refill -> FSM back to IDLE; no hit on that line; a new refill restarts at offset 0.
REQ-043 Async reset: i_reset low mid-refill, between clock edges -> o_mem_read=0 immediately; all lookups miss after release.
REQ-044 Stats (INSTR_CACHE_STATS_EN): 10 dual-hit cycles plus 1 miss -> o_hit_count=20, o_miss_count=1.

Source files
------------

// File: rtl/instr_cache.sv
// Dual-port direct-mapped instruction cache: combinational lookup with a single refill FSM.
// Define INSTR_CACHE_STATS_EN to build the hit/miss statistics counters.
module instr_cache #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic [1:0][31:0] i_cache_address,
    input  logic [1:0]      i_cache_read,
    output logic [1:0][31:0] o_cache_instr,
    output logic [1:0]      o_cache_hit,
    output logic [31:0]     o_mem_address,
    output logic            o_mem_read,
    input  logic [31:0]     i_mem_data,
    input  logic            i_mem_ready,
    input  logic            i_invalidate,
    output logic [31:0]     o_hit_count,
    output logic [31:0]     o_miss_count
);
    localparam int IW = $clog2(LINES);
    localparam int OW = $clog2(WORDS);
    localparam int TW = 32 - 2 - OW - IW;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;

    state_t                  state, state_n;
    logic [LINES-1:0]        valid;
    logic [TW-1:0]           tag_mem  [LINES];
    logic [WORDS-1:0][31:0]  data_mem [LINES];
    logic [OW-1:0]           k;
    logic [IW-1:0]           ref_idx;
    logic [TW-1:0]           ref_tag;

    logic [1:0][IW-1:0]      lk_idx;
    logic [1:0][TW-1:0]      lk_tag;
    logic [1:0][OW-1:0]      lk_off;
    logic [1:0]              hit_raw, miss;
    logic                    start;
    logic [IW-1:0]           start_idx;
    logic [TW-1:0]           start_tag;
    logic                    mem_take;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{i_cache_address[0][1:0], i_cache_address[1][1:0]};

    for (genvar p = 0; p < 2; p++) begin : g_port
        assign lk_off[p]  = i_cache_address[p][2+OW-1:2];
        assign lk_idx[p]  = i_cache_address[p][2+OW+IW-1:2+OW];
        assign lk_tag[p]  = i_cache_address[p][31:2+OW+IW];
        assign hit_raw[p] = i_cache_read[p] & valid[lk_idx[p]] & (tag_mem[lk_idx[p]] == lk_tag[p]);
        assign miss[p]    = i_cache_read[p] & ~hit_raw[p];
        // Reset gates the hit so nothing leaks out while the array is being cleared.
        assign o_cache_hit[p]   = i_reset & hit_raw[p];
        assign o_cache_instr[p] = o_cache_hit[p] ? data_mem[lk_idx[p]][lk_off[p]] : NOP_INSTR;
    end

    assign start_idx = miss[0] ? lk_idx[0] : lk_idx[1];
    assign start_tag = miss[0] ? lk_tag[0] : lk_tag[1];
    assign mem_take  = (state == REFILL) & i_mem_ready & ~i_invalidate;

    always_comb begin
        state_n = state;
        start   = 1'b0;
        case (state)
            IDLE: begin
                if (!i_invalidate && (miss != 2'b00)) begin
                    state_n = REFILL;
                    start   = 1'b1;
                end
            end
            REFILL: begin
                if (i_invalidate)
                    state_n = IDLE;
                else if (i_mem_ready && (k == OW'(WORDS-1)))
                    state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state   <= IDLE;
            valid   <= '0;
            k       <= '0;
            ref_idx <= '0;
            ref_tag <= '0;
        end else begin
            state <= state_n;
            if (i_invalidate)
                valid <= '0;
            else if (start)
                valid[start_idx] <= 1'b0;
            else if (state == DONE)
                valid[ref_idx] <= 1'b1;
            if (start) begin
                ref_idx <= start_idx;
                ref_tag <= start_tag;
                k       <= '0;
            end else if (mem_take) begin
                k <= k + 1'b1;
            end
        end
    end

    // Arrays carry no reset; valid bits alone decide whether contents are visible.
    always_ff @(posedge i_clock) begin
        if (mem_take)
            data_mem[ref_idx][k] <= i_mem_data;
        if (state == DONE && !i_invalidate)
            tag_mem[ref_idx] <= ref_tag;
    end

    assign o_mem_read    = (state == REFILL);
    assign o_mem_address = (state == REFILL) ? {ref_tag, ref_idx, k, 2'b00} : 32'h0;

`ifdef INSTR_CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            hit_cnt <= hit_cnt + {31'b0, o_cache_hit[0]} + {31'b0, o_cache_hit[1]};
            if (start)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign o_hit_count  = hit_cnt;
    assign o_miss_count = miss_cnt;
`else
    assign o_hit_count  = 32'h0;
    assign o_miss_count = 32'h0;
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Directed table-driven bench for instr_cache, plus hand sequences for reset and statistics.
module tb_instr_cache;
    localparam logic [31:0] N = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0][31:0] addr;
    logic [1:0]       rd;
    logic [1:0][31:0] instr;
    logic [1:0]       hit;
    logic [31:0]      mem_addr;
    logic             mem_read;
    logic [31:0]      mem_data;
    logic             mem_ready;
    logic             inval;
    logic [31:0]      hit_count, miss_count;

    int tests = 0;
    int errors = 0;

    instr_cache #(.LINES(16), .WORDS(4)) dut (
        .i_clock         (clk),
        .i_reset         (rst_n),
        .i_cache_address (addr),
        .i_cache_read    (rd),
        .o_cache_instr   (instr),
        .o_cache_hit     (hit),
        .o_mem_address   (mem_addr),
        .o_mem_read      (mem_read),
        .i_mem_data      (mem_data),
        .i_mem_ready     (mem_ready),
        .i_invalidate    (inval),
        .o_hit_count     (hit_count),
        .o_miss_count    (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a0, a1;
        logic [1:0]  rd;
        logic        rdy;
        logic [31:0] md;
        logic        inv;
        logic [1:0]  hit;
        logic [31:0] i0, i1;
        logic        mrd;
        logic [31:0] maddr;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic [31:0] a0, logic [31:0] a1, logic [1:0] r, logic rdy,
                                logic [31:0] md, logic inv, logic [1:0] h, logic [31:0] i0,
                                logic [31:0] i1, logic mrd, logic [31:0] maddr);
        vec_t v;
        v.a0 = a0; v.a1 = a1; v.rd = r; v.rdy = rdy; v.md = md; v.inv = inv;
        v.hit = h; v.i0 = i0; v.i1 = i1; v.mrd = mrd; v.maddr = maddr;
        return v;
    endfunction

    task automatic chk(string nm, int row, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    int exp_hits;
    int exp_stat_hits, exp_stat_miss;

    initial begin
        // Cold dual read of 0x100/0x104, ready every cycle (ignored outside REFILL)
        vt.push_back(mk(32'h100, 32'h104, 2'b11, 1, 32'hDEAD0000, 0, 2'b00, N, N, 0, 32'h0));
        vt.push_back(mk(32'h100, 32'h104, 2'b11, 1, 32'hA0, 0, 2'b00, N, N, 1, 32'h100));
        vt.push_back(mk(32'h100, 32'h104, 2'b11, 1, 32'hA1, 0, 2'b00, N, N, 1, 32'h104));
        vt.push_back(mk(32'h100, 32'h104, 2'b11, 1, 32'hA2, 0, 2'b00, N, N, 1, 32'h108));
        vt.push_back(mk(32'h100, 32'h104, 2'b11, 1, 32'hA3, 0, 2'b00, N, N, 1, 32'h10C));
        vt.push_back(mk(32'h100, 32'h104, 2'b11, 1, 32'hDEAD0001, 0, 2'b00, N, N, 0, 32'h0));
        vt.push_back(mk(32'h100, 32'h104, 2'b11, 0, 32'h0, 0, 2'b11, 32'hA0, 32'hA1, 0, 32'h0));
        vt.push_back(mk(32'h108, 32'h10C, 2'b11, 0, 32'h0, 0, 2'b11, 32'hA2, 32'hA3, 0, 32'h0));
        // Conflict: 0x200 evicts line 0
        vt.push_back(mk(32'h100, 32'h200, 2'b11, 0, 32'h0, 0, 2'b01, 32'hA0, N, 0, 32'h0));
        vt.push_back(mk(32'h100, 32'h200, 2'b11, 1, 32'hB0, 0, 2'b00, N, N, 1, 32'h200));
        vt.push_back(mk(32'h100, 32'h200, 2'b11, 1, 32'hB1, 0, 2'b00, N, N, 1, 32'h204));
        vt.push_back(mk(32'h100, 32'h200, 2'b11, 1, 32'hB2, 0, 2'b00, N, N, 1, 32'h208));
        vt.push_back(mk(32'h100, 32'h200, 2'b11, 1, 32'hB3, 0, 2'b00, N, N, 1, 32'h20C));
        vt.push_back(mk(32'h100, 32'h200, 2'b11, 0, 32'h0, 0, 2'b00, N, N, 0, 32'h0));
        vt.push_back(mk(32'h100, 32'h200, 2'b11, 0, 32'h0, 0, 2'b10, N, 32'hB0, 0, 32'h0));
        // Refill of 0x100 with a 3-cycle stall on word 2
        vt.push_back(mk(32'h100, 32'h0, 2'b01, 1, 32'hC0, 0, 2'b00, N, N, 1, 32'h100));
        vt.push_back(mk(32'h100, 32'h0, 2'b01, 1, 32'hC1, 0, 2'b00, N, N, 1, 32'h104));
        vt.push_back(mk(32'h100, 32'h0, 2'b01, 0, 32'h0, 0, 2'b00, N, N, 1, 32'h108));
        vt.push_back(mk(32'h100, 32'h0, 2'b01, 0, 32'h0, 0, 2'b00, N, N, 1, 32'h108));
        vt.push_back(mk(32'h100, 32'h0, 2'b01, 0, 32'h0, 0, 2'b00, N, N, 1, 32'h108));
        vt.push_back(mk(32'h100, 32'h0, 2'b01, 1, 32'hC2, 0, 2'b00, N, N, 1, 32'h108));
        vt.push_back(mk(32'h100, 32'h0, 2'b01, 1, 32'hC3, 0, 2'b00, N, N, 1, 32'h10C));
        vt.push_back(mk(32'h100, 32'h10C, 2'b11, 0, 32'h0, 0, 2'b00, N, N, 0, 32'h0));
        vt.push_back(mk(32'h100, 32'h10C, 2'b11, 0, 32'h0, 0, 2'b11, 32'hC0, 32'hC3, 0, 32'h0));
        // Flush during word 1, then restart from offset 0
        vt.push_back(mk(32'h300, 32'h0, 2'b01, 0, 32'h0, 0, 2'b00, N, N, 0, 32'h0));
        vt.push_back(mk(32'h300, 32'h0, 2'b01, 1, 32'hD0, 0, 2'b00, N, N, 1, 32'h300));
        vt.push_back(mk(32'h300, 32'h0, 2'b01, 0, 32'h0, 1, 2'b00, N, N, 1, 32'h304));
        vt.push_back(mk(32'h300, 32'h0, 2'b01, 0, 32'h0, 0, 2'b00, N, N, 0, 32'h0));
        vt.push_back(mk(32'h300, 32'h0, 2'b01, 1, 32'hE0, 0, 2'b00, N, N, 1, 32'h300));
        vt.push_back(mk(32'h300, 32'h0, 2'b01, 1, 32'hE1, 0, 2'b00, N, N, 1, 32'h304));
        vt.push_back(mk(32'h300, 32'h0, 2'b01, 1, 32'hE2, 0, 2'b00, N, N, 1, 32'h308));
        vt.push_back(mk(32'h300, 32'h0, 2'b01, 1, 32'hE3, 0, 2'b00, N, N, 1, 32'h30C));
        vt.push_back(mk(32'h300, 32'h30C, 2'b11, 0, 32'h0, 0, 2'b00, N, N, 0, 32'h0));
        vt.push_back(mk(32'h300, 32'h30C, 2'b11, 0, 32'h0, 0, 2'b11, 32'hE0, 32'hE3, 0, 32'h0));
        // Lookup alongside invalidate sees the old valid bits; afterwards the line misses
        vt.push_back(mk(32'h300, 32'h308, 2'b11, 0, 32'h0, 1, 2'b11, 32'hE0, 32'hE2, 0, 32'h0));
        vt.push_back(mk(32'h300, 32'h0, 2'b01, 0, 32'h0, 0, 2'b00, N, N, 0, 32'h0));
        vt.push_back(mk(32'h300, 32'h0, 2'b01, 0, 32'h0, 0, 2'b00, N, N, 1, 32'h300));

        exp_hits = 0;
        foreach (vt[i]) exp_hits += int'(vt[i].hit[0]) + int'(vt[i].hit[1]);
`ifdef INSTR_CACHE_STATS_EN
        exp_stat_hits = exp_hits;
        exp_stat_miss = 6;
`else
        exp_stat_hits = 0;
        exp_stat_miss = 0;
`endif

        // Reset state with a read pending
        rst_n = 1'b0; addr = '0; addr[0] = 32'h100; rd = 2'b01;
        mem_data = '0; mem_ready = 1'b0; inval = 1'b0;
        #2;
        chk("reset_hit", -1, {30'b0, hit}, 32'h0);
        chk("reset_instr0", -1, instr[0], N);
        chk("reset_mem_read", -1, {31'b0, mem_read}, 32'h0);
        chk("reset_mem_addr", -1, mem_addr, 32'h0);
        chk("reset_hit_count", -1, hit_count, 32'h0);
        chk("reset_miss_count", -1, miss_count, 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            if (i != 0) @(negedge clk);
            addr[0] = vt[i].a0; addr[1] = vt[i].a1; rd = vt[i].rd;
            mem_ready = vt[i].rdy; mem_data = vt[i].md; inval = vt[i].inv;
            #1;
            chk("hit", i, {30'b0, hit}, {30'b0, vt[i].hit});
            chk("instr0", i, instr[0], vt[i].i0);
            chk("instr1", i, instr[1], vt[i].i1);
            chk("mem_read", i, {31'b0, mem_read}, {31'b0, vt[i].mrd});
            chk("mem_addr", i, mem_addr, vt[i].maddr);
        end

        @(negedge clk);
        rd = 2'b00; mem_ready = 1'b0; inval = 1'b0;
        #1;
        chk("stat_hits", 100, hit_count, exp_stat_hits);
        chk("stat_miss", 100, miss_count, exp_stat_miss);
        chk("stalled_mem_read", 100, {31'b0, mem_read}, 32'h1);

        // Async reset mid-refill, between edges, with a late ready
        #2;
        rst_n = 1'b0; mem_ready = 1'b1; mem_data = 32'hBAD0BAD0;
        addr[0] = 32'h300; addr[1] = 32'h100; rd = 2'b11;
        #1;
        chk("async_mem_read", 101, {31'b0, mem_read}, 32'h0);
        chk("async_mem_addr", 101, mem_addr, 32'h0);
        chk("async_hit", 101, {30'b0, hit}, 32'h0);
        chk("async_hit_count", 101, hit_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        addr[0] = 32'h100; addr[1] = 32'h104;
        #1;
        chk("post_reset_hit", 102, {30'b0, hit}, 32'h0);
        chk("post_reset_mem_read", 102, {31'b0, mem_read}, 32'h0);

        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            mem_data = 32'hF0 + w; mem_ready = 1'b1;
            #1;
            chk("stats_refill_addr", 103 + w, mem_addr, 32'h100 + 4 * w);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("stats_done_mem_read", 107, {31'b0, mem_read}, 32'h0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            chk("stats_dual_hit", 108 + c, {30'b0, hit}, 32'h3);
            chk("stats_dual_instr", 108 + c, instr[0] ^ instr[1], 32'hF0 ^ 32'hF1);
        end
        @(negedge clk);
        rd = 2'b00;
        #1;
`ifdef INSTR_CACHE_STATS_EN
        chk("stats_hit_count", 118, hit_count, 32'd20);
        chk("stats_miss_count", 118, miss_count, 32'd1);
`else
        chk("stats_hit_count", 118, hit_count, 32'd0);
        chk("stats_miss_count", 118, miss_count, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
